// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential fetch, branch/jump redirect, wrong-path flush,
// misaligned-target trap and saturating branch statistics.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStall,
  input  logic               iResolveValid,
  input  logic               iTaken,
  input  logic               iIsJump,
  input  logic [31:0]        iPCTarget,
  input  logic [31:0]        iResolvePC,
  output logic [31:0]        oPC,
  output logic               oFlush,
  output logic               oTrap,
  output logic [31:0]        oEPC,
  output logic [COUNT_W-1:0] oBranchCount,
  output logic [COUNT_W-1:0] oTakenCount
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]         CNT_INIT = 4'(FLUSH_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        pc_d, epc_d;
  logic               trap_d;
  logic [COUNT_W-1:0] br_d, tk_d;
  logic               redirect, misaligned;

  assign redirect   = iResolveValid & iTaken;
  assign misaligned = |iPCTarget[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = oPC;
    epc_d   = oEPC;
    trap_d  = 1'b0;
    br_d    = oBranchCount;
    tk_d    = oTakenCount;
    unique case (state_q)
      RUN: begin
        if (iResolveValid) begin
          if (!iIsJump && oBranchCount != CNT_MAX)
            br_d = oBranchCount + 1'b1;
          if (iTaken && oTakenCount != CNT_MAX)
            tk_d = oTakenCount + 1'b1;
        end
        if (redirect && misaligned) begin
          pc_d    = TRAP_VECTOR;
          epc_d   = iResolvePC;
          trap_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = FLUSH;
        end else if (redirect) begin
          pc_d    = iPCTarget;
          cnt_d   = CNT_INIT;
          state_d = FLUSH;
        end else if (!iStall) begin
          pc_d = oPC + 32'd4;
        end
      end
      FLUSH: begin
        // wrong-path slots drain; stall and resolves are ignored here
        pc_d  = oPC + 32'd4;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= RUN;
      cnt_q        <= 4'd0;
      oPC          <= RESET_VECTOR;
      oTrap        <= 1'b0;
      oEPC         <= 32'd0;
      oBranchCount <= '0;
      oTakenCount  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      oPC          <= pc_d;
      oTrap        <= trap_d;
      oEPC         <= epc_d;
      oBranchCount <= br_d;
      oTakenCount  <= tk_d;
    end
  end

  assign oFlush = (state_q == FLUSH);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: reference model plus directed redirect,
// trap, stall, wrong-path, saturation, wrap and async-reset vectors.
module tb_pc_redirect_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iStall, iResolveValid, iTaken, iIsJump;
  logic [31:0] iPCTarget, iResolvePC;

  logic [31:0] pc_a, epc_a, pc_b, epc_b;
  logic        flush_a, trap_a, flush_b, trap_b;
  logic [15:0] br_a, tk_a;
  logic [1:0]  br_b, tk_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 iCLK = ~iCLK;

  pc_redirect_ctrl dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStall(iStall),
    .iResolveValid(iResolveValid), .iTaken(iTaken), .iIsJump(iIsJump),
    .iPCTarget(iPCTarget), .iResolvePC(iResolvePC),
    .oPC(pc_a), .oFlush(flush_a), .oTrap(trap_a), .oEPC(epc_a),
    .oBranchCount(br_a), .oTakenCount(tk_a)
  );

  pc_redirect_ctrl #(.COUNT_W(2)) dut2 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStall(iStall),
    .iResolveValid(iResolveValid), .iTaken(iTaken), .iIsJump(iIsJump),
    .iPCTarget(iPCTarget), .iResolvePC(iResolvePC),
    .oPC(pc_b), .oFlush(flush_b), .oTrap(trap_b), .oEPC(epc_b),
    .oBranchCount(br_b), .oTakenCount(tk_b)
  );

  // reference model: flush as a remaining-slot count, counts as plain ints
  logic [31:0] m_pc, m_epc;
  int          m_left, m_br, m_tk;
  bit          m_trap;

  function automatic int sat(int v, int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      m_pc = 32'h0; m_epc = 32'h0; m_left = 0;
      m_br = 0; m_tk = 0; m_trap = 0;
    end else begin
      m_trap = 0;
      if (m_left > 0) begin
        m_pc = m_pc + 32'd4;
        m_left--;
      end else begin
        if (iResolveValid) begin
          if (!iIsJump) m_br++;
          if (iTaken) m_tk++;
        end
        if (iResolveValid && iTaken) begin
          if (iPCTarget % 4 != 0) begin
            m_pc = 32'h100; m_epc = iResolvePC; m_trap = 1;
          end else begin
            m_pc = iPCTarget;
          end
          m_left = 2;
        end else if (!iStall) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iCLK) begin
    chk("pc",      pc_a,           m_pc);
    chk("flush",   32'(flush_a),   32'(m_left > 0));
    chk("trap",    32'(trap_a),    32'(m_trap));
    chk("epc",     epc_a,          m_epc);
    chk("br16",    32'(br_a),      32'(sat(m_br, 16)));
    chk("tk16",    32'(tk_a),      32'(sat(m_tk, 16)));
    chk("pc_w2",   pc_b,           m_pc);
    chk("flush_w2",32'(flush_b),   32'(m_left > 0));
    chk("br2",     32'(br_b),      32'(sat(m_br, 2)));
    chk("tk2",     32'(tk_b),      32'(sat(m_tk, 2)));
  end

  task automatic tick();
    @(negedge iCLK);
    #2;
  endtask

  task automatic drive(bit rv, bit tk, bit j, logic [31:0] tgt,
                       logic [31:0] rpc);
    iResolveValid = rv;
    iTaken        = tk;
    iIsJump       = j;
    iPCTarget     = tgt;
    iResolvePC    = rpc;
  endtask

  initial begin
    iRST_N = 1'b0;
    iStall = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_flush", 32'(flush_a), 0);
    chk("rst_trap", 32'(trap_a), 0);
    chk("rst_epc", epc_a, 32'h0);
    chk("rst_cnt", {br_a, tk_a}, 32'h0);
    iRST_N = 1'b1;
    tick(); chk("seq4", pc_a, 32'h4);
    tick(); chk("seq8", pc_a, 32'h8);
    tick(); chk("seq12", pc_a, 32'hC);
    tick(); chk("seq16", pc_a, 32'h10);

    drive(1, 1, 0, 32'h40, 32'h10);
    tick();
    chk("br_pc", pc_a, 32'h40);
    chk("br_flush", 32'(flush_a), 1);
    chk("br_bc", 32'(br_a), 1);
    chk("br_tc", 32'(tk_a), 1);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("fl_pc1", pc_a, 32'h44);
    chk("fl_on2", 32'(flush_a), 1);
    tick();
    chk("fl_pc2", pc_a, 32'h48);
    chk("fl_off", 32'(flush_a), 0);

    drive(1, 1, 1, 32'h42, 32'h30);
    tick();
    chk("trap_pc", pc_a, 32'h100);
    chk("trap_on", 32'(trap_a), 1);
    chk("trap_epc", epc_a, 32'h30);
    chk("trap_bc", 32'(br_a), 1);
    chk("trap_tc", 32'(tk_a), 2);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("trap_off", 32'(trap_a), 0);
    chk("trap_epc_hold", epc_a, 32'h30);
    tick();
    chk("trap_run_pc", pc_a, 32'h108);

    iStall = 1'b1;
    drive(1, 1, 0, 32'h80, 32'h108);
    tick();
    chk("stall_redir", pc_a, 32'h80);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("flush_ign_stall", pc_a, 32'h84);
    tick();
    repeat (3) tick();
    chk("stall_hold", pc_a, 32'h88);
    iStall = 1'b0;

    drive(1, 1, 0, 32'h200, 32'h88);
    tick();
    chk("wp_pc0", pc_a, 32'h200);
    drive(1, 1, 0, 32'h300, 32'h200);
    tick();
    chk("wp_pc1", pc_a, 32'h204);
    chk("wp_tc", 32'(tk_a), 4);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("wp_pc2", pc_a, 32'h208);
    chk("wp_noflush", 32'(flush_a), 0);

    drive(1, 0, 0, 32'h0, 32'h208);
    repeat (5) tick();
    drive(0, 0, 0, 0, 0);
    chk("nt_pc", pc_a, 32'h21C);
    chk("sat_br16", 32'(br_a), 8);
    chk("sat_br2", 32'(br_b), 3);
    chk("sat_tk2", 32'(tk_b), 3);

    drive(1, 1, 0, 32'hFFFF_FFF4, 32'h21C);
    tick();
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    chk("wrap_pre", pc_a, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero", pc_a, 32'h0);

    drive(1, 1, 0, 32'h400, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("mid_flush", 32'(flush_a), 1);
    #1 iRST_N = 1'b0;
    #1;
    chk("async_pc", pc_a, 32'h0);
    chk("async_flush", 32'(flush_a), 0);
    chk("async_cnt", {br_a, tk_a}, 32'h0);
    tick();
    iRST_N = 1'b1;
    tick();
    chk("post_rst_pc", pc_a, 32'h4);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
